// File: rtl/mem_q_pkg.sv
// Shared encodings, field widths and a constant clog2 helper for the
// out-of-order-response memory stage queue.
package mem_q_pkg;

  localparam logic [1:0] LD_SIZE_B = 2'd0;
  localparam logic [1:0] LD_SIZE_H = 2'd1;
  localparam logic [1:0] LD_SIZE_W = 2'd2;

  localparam int DATA_W    = 32;
  localparam int SIZE_W    = 2;
  localparam int LANE_W    = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_ooq_ld_extract.sv
// Load data extraction: byte-lane shift of rdata, then 8/16/32-bit
// sign- or zero-extension.
module ld_extract
  import mem_q_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [LANE_W-1:0] addr,
  input  logic [SIZE_W-1:0] size,
  input  logic              sign,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {addr, 3'b000};

  // NOTE: every branch of a combinational case must assign the output (a
  // default arm here) or synthesis infers a latch to hold the old value.
  always_comb begin
    case (size)
      LD_SIZE_B: result = {{24{sign & shifted[7]}},  shifted[7:0]};
      LD_SIZE_H: result = {{16{sign & shifted[15]}}, shifted[15:0]};
      default:   result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_ooq.sv
// In-order memory-stage queue tolerating variable-latency data_ok responses.
// Define MEM_FWD_EN to drive the per-entry fwd_* ports; otherwise they read 0.
module mem_stage_ooq
  import mem_q_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_allowin,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  input  logic                       in_need_rsp,
  input  logic                       in_is_load,
  input  logic [SIZE_W-1:0]          in_ld_size,
  input  logic                       in_ld_sign,
  input  logic [DATA_W-1:0]          in_alu_result,
  input  logic                       data_ok,
  input  logic [DATA_W-1:0]          rdata,
  output logic                       out_valid,
  input  logic                       out_allowin,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [DATA_W-1:0]          out_result,
  output logic [clog2(DEPTH+1)-1:0]  pend_cnt,
  output logic [DEPTH-1:0]           fwd_valid,
  output logic [DEPTH-1:0]           fwd_done,
  output logic [DEPTH*PAYLOAD_W-1:0] fwd_payload,
  output logic [DEPTH*DATA_W-1:0]    fwd_result
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [DATA_W-1:0]    result_q  [DEPTH];
  logic [SIZE_W-1:0]    ld_size_q [DEPTH];
  logic [LANE_W-1:0]    lane_q    [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     done_q;
  logic [DEPTH-1:0]     need_rsp_q;
  logic [DEPTH-1:0]     is_load_q;
  logic [DEPTH-1:0]     ld_sign_q;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] discard_cnt;

  logic [PTR_W-1:0]  rsp_ptr;
  logic              rsp_found;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rsp_data;
  logic              take;
  logic              retire;
  logic              rsp_drop;
  logic              rsp_hit;

  // Oldest-first scan for the entry the next data_ok belongs to.
  always_comb begin
    rsp_ptr   = head;
    rsp_found = 1'b0;
    wait_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head + PTR_W'(i);
      if (valid_q[idx] && need_rsp_q[idx] && !done_q[idx]) begin
        wait_cnt = wait_cnt + CNT_W'(1);
        if (!rsp_found) begin
          rsp_ptr   = idx;
          rsp_found = 1'b1;
        end
      end
    end
  end

  ld_extract u_ld_extract (
    .rdata  (rdata),
    .addr   (lane_q[rsp_ptr]),
    .size   (ld_size_q[rsp_ptr]),
    .sign   (ld_sign_q[rsp_ptr]),
    .result (rsp_data)
  );

  assign out_valid   = valid_q[head] && done_q[head];
  assign out_payload = out_valid ? payload_q[head] : '0;
  assign out_result  = out_valid ? result_q[head]  : '0;
  assign retire      = out_valid && out_allowin;
  assign in_allowin  = (SUM_W'(count) + SUM_W'(discard_cnt) < SUM_W'(DEPTH)) || retire;
  assign take        = in_valid && in_allowin && !flush;
  assign rsp_drop    = data_ok && (discard_cnt != '0);
  assign rsp_hit     = data_ok && (discard_cnt == '0) && rsp_found;
  assign pend_cnt    = count + discard_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      valid_q     <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      discard_cnt <= discard_cnt - CNT_W'(rsp_drop) + wait_cnt - CNT_W'(rsp_hit);
    end else begin
      if (rsp_drop) discard_cnt <= discard_cnt - CNT_W'(1);
      // Retire before enqueue: on a full queue both hit the same slot.
      if (retire) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (take) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(take) - CNT_W'(retire);
    end
  end

  // NOTE: entry storage is not reset; valid_q gates every use of it, so
  // clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (take) begin
      payload_q[tail]  <= in_payload;
      result_q[tail]   <= in_alu_result;
      ld_size_q[tail]  <= in_ld_size;
      lane_q[tail]     <= in_alu_result[LANE_W-1:0];
      need_rsp_q[tail] <= in_need_rsp;
      is_load_q[tail]  <= in_is_load;
      ld_sign_q[tail]  <= in_ld_sign;
      done_q[tail]     <= !in_need_rsp;
    end
    if (rsp_hit) begin
      done_q[rsp_ptr] <= 1'b1;
      if (is_load_q[rsp_ptr]) result_q[rsp_ptr] <= rsp_data;
    end
  end

`ifdef MEM_FWD_EN
  always_comb begin
    fwd_valid   = '0;
    fwd_done    = '0;
    fwd_payload = '0;
    fwd_result  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head + PTR_W'(i);
      if (valid_q[idx]) begin
        fwd_valid[i]                          = 1'b1;
        fwd_done[i]                           = done_q[idx];
        fwd_payload[i*PAYLOAD_W +: PAYLOAD_W] = payload_q[idx];
        fwd_result[i*DATA_W +: DATA_W]        = result_q[idx];
      end
    end
  end
`else
  assign fwd_valid   = '0;
  assign fwd_done    = '0;
  assign fwd_payload = '0;
  assign fwd_result  = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ooq.sv
// Randomized plus directed bench for mem_stage_ooq against a queue-based
// reference model of the in-order retire / response-matching rules.
module tb_mem_stage_ooq;
  import mem_q_pkg::*;

  localparam int DEPTH     = 2;
  localparam int PAYLOAD_W = 64;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic                       clk = 1'b0;
  logic                       reset, flush, in_valid, in_need_rsp, in_is_load, in_ld_sign;
  logic                       data_ok, out_allowin;
  logic                       in_allowin, out_valid;
  logic [PAYLOAD_W-1:0]       in_payload, out_payload;
  logic [1:0]                 in_ld_size;
  logic [31:0]                in_alu_result, rdata, out_result;
  logic [CNT_W-1:0]           pend_cnt;
  logic [DEPTH-1:0]           fwd_valid, fwd_done;
  logic [DEPTH*PAYLOAD_W-1:0] fwd_payload;
  logic [DEPTH*32-1:0]        fwd_result;

  always #5 clk = ~clk;

  mem_stage_ooq #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
    .in_need_rsp(in_need_rsp), .in_is_load(in_is_load), .in_ld_size(in_ld_size),
    .in_ld_sign(in_ld_sign), .in_alu_result(in_alu_result),
    .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
    .out_result(out_result), .pend_cnt(pend_cnt),
    .fwd_valid(fwd_valid), .fwd_done(fwd_done),
    .fwd_payload(fwd_payload), .fwd_result(fwd_result)
  );

  typedef struct {
    logic [63:0] payload;
    bit          need;
    bit          done;
    bit          is_load;
    logic [1:0]  size;
    bit          sign;
    logic [31:0] addr;
    logic [31:0] result;
  } ent_t;

  typedef struct {
    bit          rst, fl, iv, need, load, sign, dok, oa;
    logic [1:0]  size;
    logic [31:0] alu, rd;
    logic [63:0] pl;
  } stim_t;

  ent_t  q[$];
  int    discard;
  int    n_checks, n_pass;
  logic  last_allowin;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ext(input logic [31:0] rd, input logic [31:0] addr,
                                      input logic [1:0] size, input bit sign);
    int unsigned sh;
    longint      v;
    sh = rd >> (8 * addr[1:0]);
    v  = sh;
    if (size == 2'd0) begin
      v = v % 256;
      if (sign && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (sign && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t ld_stim(input logic [31:0] alu, input logic [1:0] size,
                                    input bit sign, input logic [63:0] pl);
    stim_t s;
    s = idle();
    s.iv = 1; s.load = 1; s.need = 1; s.size = size; s.sign = sign; s.alu = alu; s.pl = pl;
    return s;
  endfunction

  function automatic int waiting();
    int n;
    n = 0;
    foreach (q[i]) if (q[i].need && !q[i].done) n++;
    return n;
  endfunction

  task automatic check_outputs();
    logic             ov;
    logic [DEPTH-1:0] ev, ed;
    logic [63:0]      epl, efp;
    logic [31:0]      ers, efr;
    ov  = (q.size() > 0) && q[0].done;
    epl = '0; ers = '0; efp = '0; efr = '0; ev = '0; ed = '0;
    if (ov) begin
      epl = q[0].payload;
      ers = q[0].result;
    end
`ifdef MEM_FWD_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (i < q.size()) begin
        ev[i] = 1'b1;
        ed[i] = q[i].done;
      end
    end
    if (q.size() > 0) begin
      efp = q[0].payload;
      efr = q[0].result;
    end
`endif
    check("out_valid", out_valid, ov);
    check("out_result", out_result, ers);
    check("out_payload", out_payload, epl);
    check("pend_cnt", pend_cnt, q.size() + discard);
    check("fwd_valid", fwd_valid, ev);
    check("fwd_done", fwd_done, ed);
    check("fwd_payload0", fwd_payload[63:0], efp);
    check("fwd_result0", fwd_result[31:0], efr);
  endtask

  // One clock: drive at posedge+1, judge in_allowin, advance model, check after edge.
  task automatic cycle(input stim_t s);
    logic ov, al, found;
    ent_t e;
    reset = s.rst; flush = s.fl; in_valid = s.iv; in_need_rsp = s.need;
    in_is_load = s.load; in_ld_size = s.size; in_ld_sign = s.sign;
    in_alu_result = s.alu; in_payload = s.pl; data_ok = s.dok; rdata = s.rd;
    out_allowin = s.oa;
    #1;
    ov = (q.size() > 0) && q[0].done;
    al = (q.size() + discard < DEPTH) || (ov && s.oa);
    last_allowin = in_allowin;
    check("in_allowin", in_allowin, al);
    if (s.rst) begin
      q.delete();
      discard = 0;
    end else begin
      if (s.dok) begin
        if (discard > 0) discard--;
        else begin
          found = 0;
          for (int i = 0; i < q.size(); i++) begin
            if (!found && q[i].need && !q[i].done) begin
              found     = 1;
              q[i].done = 1;
              if (q[i].is_load) q[i].result = ext(s.rd, q[i].addr, q[i].size, q[i].sign);
            end
          end
        end
      end
      if (ov && s.oa) void'(q.pop_front());
      if (s.fl) begin
        discard += waiting();
        q.delete();
      end else if (s.iv && al) begin
        e.payload = s.pl; e.need = s.need; e.done = !s.need; e.is_load = s.load;
        e.size = s.size; e.sign = s.sign; e.addr = s.alu; e.result = s.alu;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    stim_t s;
    n_checks = 0; n_pass = 0; discard = 0;
    reset = 1; flush = 0; in_valid = 0; in_need_rsp = 0; in_is_load = 0;
    in_ld_size = 0; in_ld_sign = 0; in_alu_result = 0; in_payload = 0;
    data_ok = 0; rdata = 0; out_allowin = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("reset_allowin", in_allowin, 1);

    // Word load, data_ok three cycles after enqueue.
    cycle(ld_stim(32'h100, LD_SIZE_W, 0, 64'hA1));
    cycle(idle());
    cycle(idle());
    s = idle(); s.dok = 1; s.rd = 32'h8899AABB; cycle(s);
    check("word_ld_valid", out_valid, 1);
    check("word_ld_data", out_result, 32'h8899AABB);
    s = idle(); s.oa = 1; cycle(s);

    // Signed byte and unsigned half from lane 2.
    cycle(ld_stim(32'h202, LD_SIZE_B, 1, 64'hA2));
    s = idle(); s.dok = 1; s.rd = 32'h00F30000; cycle(s);
    check("lb_sign", out_result, 32'hFFFFFFF3);
    s = idle(); s.oa = 1; cycle(s);
    cycle(ld_stim(32'h1002, LD_SIZE_H, 0, 64'hA3));
    s = idle(); s.dok = 1; s.rd = 32'h80000000; cycle(s);
    check("lhu_zero", out_result, 32'h00008000);
    s = idle(); s.oa = 1; cycle(s);

    // Full queue blocks, responses in consecutive cycles retire in order.
    cycle(ld_stim(32'h200, LD_SIZE_W, 0, 64'hB1));
    cycle(ld_stim(32'h204, LD_SIZE_W, 0, 64'hB2));
    cycle(ld_stim(32'h208, LD_SIZE_W, 0, 64'hB3));
    check("full_allowin", last_allowin, 0);
    s = idle(); s.dok = 1; s.rd = 32'h11111111; cycle(s);
    s = idle(); s.dok = 1; s.rd = 32'h22222222; cycle(s);
    check("order_pl0", out_payload, 64'hB1);
    s = idle(); s.oa = 1; cycle(s);
    check("order_pl1", out_payload, 64'hB2);
    check("order_rs1", out_result, 32'h22222222);
    s = idle(); s.oa = 1; cycle(s);

    // Flush with two loads outstanding: their responses are discarded.
    cycle(ld_stim(32'h300, LD_SIZE_W, 0, 64'hC1));
    cycle(ld_stim(32'h304, LD_SIZE_W, 0, 64'hC2));
    s = idle(); s.fl = 1; cycle(s);
    check("flush_pend", pend_cnt, 2);
    check("flush_empty", out_valid, 0);
    s = idle(); s.dok = 1; s.rd = 32'hDEAD0001; cycle(s);
    s = idle(); s.dok = 1; s.rd = 32'hDEAD0002; cycle(s);
    check("drop_pend", pend_cnt, 0);
    cycle(ld_stim(32'h308, LD_SIZE_W, 0, 64'hC3));
    s = idle(); s.dok = 1; s.rd = 32'hCAFEF00D; cycle(s);
    check("post_flush_data", out_result, 32'hCAFEF00D);
    check("post_flush_pl", out_payload, 64'hC3);
    s = idle(); s.oa = 1; cycle(s);

    // Full queue of done entries: retire and enqueue in one cycle.
    s = idle(); s.iv = 1; s.alu = 32'h11; s.pl = 64'hD1; cycle(s);
    s = idle(); s.iv = 1; s.alu = 32'h22; s.pl = 64'hD2; cycle(s);
    s = idle(); s.iv = 1; s.alu = 32'h33; s.pl = 64'hD3; s.oa = 1; cycle(s);
    check("swap_allowin", last_allowin, 1);
    check("swap_count", pend_cnt, 2);
    check("swap_head", out_payload, 64'hD2);
    s = idle(); s.oa = 1; cycle(s);
    cycle(s);

    // Reset with two loads pending.
    cycle(ld_stim(32'h400, LD_SIZE_W, 0, 64'hE1));
    cycle(ld_stim(32'h404, LD_SIZE_W, 0, 64'hE2));
    s = idle(); s.rst = 1; cycle(s);
    check("rst_valid", out_valid, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_allowin", in_allowin, 1);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 299) == 0);
      s.fl   = ($urandom_range(0, 39) == 0);
      s.iv   = $urandom_range(0, 1);
      s.load = ($urandom_range(0, 2) != 0);
      s.need = s.load ? 1'b1 : 1'($urandom_range(0, 1));
      s.size = 2'($urandom_range(0, 2));
      s.sign = $urandom_range(0, 1);
      s.alu  = $urandom;
      s.pl   = {$urandom, $urandom};
      s.dok  = ((waiting() + discard) > 0) && ($urandom_range(0, 2) == 0);
      s.rd   = $urandom;
      s.oa   = ($urandom_range(0, 3) != 0);
      cycle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
